// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Takes one EX result per handshake and either
// passes ALU data straight through (1 cycle), flags a misaligned access
// (1 cycle), or runs one data-memory request and returns the store/load result.
//
// Ports
//   clk_i, rst_n_i        clock, async active-low reset
//   valid_i / ready_o     EX result handshake (ready only in IDLE)
//   alu_res_i, st_data_i  address or writeback data, store data
//   mem_rd_i, mem_wr_i    load / store request (store wins if both set)
//   size_i, unsigned_i    access size (00 B, 01 H, 1x W), load zero-extend
//   wR_i, rf_we_i         destination register and write enable
//   dm_*                  data-memory request bus and completion
//   valid_o, wD_o, wR_o,  one-cycle result pulse to the MEM pipeline register
//   rf_we_o, misalign_o
module mem_access (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] st_data_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [4:0]  wR_i,
    input  logic        rf_we_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        valid_o,
    output logic [31:0] wD_o,
    output logic [4:0]  wR_o,
    output logic        rf_we_o,
    output logic        misalign_o
);

    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned BEW = 4;

    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e           state_q, state_d;
    logic             dm_req_q, dm_req_d;
    logic             dm_we_q, dm_we_d;
    logic [DW-1:0]    dm_addr_q, dm_addr_d;
    logic [BEW-1:0]   dm_be_q, dm_be_d;
    logic [DW-1:0]    dm_wdata_q, dm_wdata_d;
    logic [1:0]       a_lo_q, a_lo_d;
    logic [1:0]       size_lat_q, size_lat_d;
    logic             uns_lat_q, uns_lat_d;
    logic [RW-1:0]    wr_lat_q, wr_lat_d;
    logic             rf_we_lat_q, rf_we_lat_d;
    logic             valid_q, valid_d;
    logic [DW-1:0]    wd_q, wd_d;
    logic [RW-1:0]    wr_q, wr_d;
    logic             rf_we_q, rf_we_d;
    logic             mis_q, mis_d;

    logic             misalign_c;
    logic [BEW-1:0]   be_c;
    logic [DW-1:0]    wdata_c;
    logic [7:0]       ld_byte_c;
    logic [15:0]      ld_half_c;
    logic [DW-1:0]    load_c;

    // Request decode from the incoming EX result, and load extraction from the latched access
    always_comb begin
        misalign_c = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = st_data_i;
        case (size_i)
            2'b00: begin
                be_c    = 4'b0001 << alu_res_i[1:0];
                wdata_c = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                misalign_c = alu_res_i[0];
                be_c       = 4'b0011 << {alu_res_i[1], 1'b0};
                wdata_c    = {2{st_data_i[15:0]}};
            end
            default: misalign_c = |alu_res_i[1:0];
        endcase

        ld_byte_c = dm_rdata_i[{a_lo_q, 3'b000} +: 8];
        ld_half_c = dm_rdata_i[{a_lo_q[1], 4'b0000} +: 16];
        case (size_lat_q)
            2'b00:   load_c = {{24{~uns_lat_q & ld_byte_c[7]}}, ld_byte_c};
            2'b01:   load_c = {{16{~uns_lat_q & ld_half_c[15]}}, ld_half_c};
            default: load_c = dm_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        a_lo_d      = a_lo_q;
        size_lat_d  = size_lat_q;
        uns_lat_d   = uns_lat_q;
        wr_lat_d    = wr_lat_q;
        rf_we_lat_d = rf_we_lat_q;
        valid_d     = 1'b0;
        rf_we_d     = 1'b0;
        mis_d       = 1'b0;
        wd_d        = wd_q;
        wr_d        = wr_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!(mem_rd_i || mem_wr_i)) begin
                        valid_d = 1'b1;
                        wd_d    = alu_res_i;
                        wr_d    = wR_i;
                        rf_we_d = rf_we_i;
                    end else if (misalign_c) begin
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        wd_d    = '0;
                        wr_d    = wR_i;
                    end else begin
                        state_d     = S_REQ;
                        dm_req_d    = 1'b1;
                        dm_we_d     = mem_wr_i;
                        dm_addr_d   = {alu_res_i[31:2], 2'b00};
                        dm_be_d     = be_c;
                        dm_wdata_d  = wdata_c;
                        a_lo_d      = alu_res_i[1:0];
                        size_lat_d  = size_i;
                        uns_lat_d   = unsigned_i;
                        wr_lat_d    = wR_i;
                        rf_we_lat_d = rf_we_i;
                    end
                end
            end
            S_REQ: begin
                if (dm_ack_i) begin
                    state_d  = S_IDLE;
                    dm_req_d = 1'b0;
                    dm_we_d  = 1'b0;
                    dm_be_d  = '0;
                    valid_d  = 1'b1;
                    wr_d     = wr_lat_q;
                    if (dm_we_q) begin
                        wd_d = '0;
                    end else begin
                        wd_d    = load_c;
                        rf_we_d = rf_we_lat_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= '0;
            dm_wdata_q  <= '0;
            a_lo_q      <= '0;
            size_lat_q  <= '0;
            uns_lat_q   <= 1'b0;
            wr_lat_q    <= '0;
            rf_we_lat_q <= 1'b0;
            valid_q     <= 1'b0;
            wd_q        <= '0;
            wr_q        <= '0;
            rf_we_q     <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
            a_lo_q      <= a_lo_d;
            size_lat_q  <= size_lat_d;
            uns_lat_q   <= uns_lat_d;
            wr_lat_q    <= wr_lat_d;
            rf_we_lat_q <= rf_we_lat_d;
            valid_q     <= valid_d;
            wd_q        <= wd_d;
            wr_q        <= wr_d;
            rf_we_q     <= rf_we_d;
            mis_q       <= mis_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign dm_req_o   = dm_req_q;
    assign dm_we_o    = dm_we_q;
    assign dm_addr_o  = dm_addr_q;
    assign dm_be_o    = dm_be_q;
    assign dm_wdata_o = dm_wdata_q;
    assign valid_o    = valid_q;
    assign wD_o       = wd_q;
    assign wR_o       = wr_q;
    assign rf_we_o    = rf_we_q;
    assign misalign_o = mis_q;

endmodule
